// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int unsigned KEY_CNT       = 16;
  localparam int unsigned ROW_CNT       = 4;
  localparam int unsigned CODE_W        = 4;
  localparam int unsigned EVT_W         = 8;
  localparam int unsigned EVT_PRESS_BIT = 7;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } COL_STATE;

  // Matrix index (col*4 + row) to key code; element 0 is the rightmost entry.
  localparam logic [KEY_CNT-1:0][CODE_W-1:0] KEYMAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  // One-cold column drive, indexed by COL_STATE.
  localparam logic [3:0][ROW_CNT-1:0] COL_DRIVE = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [CODE_W-1:0] lowestSet(input logic [KEY_CNT-1:0] vec);
    lowestSet = '0;
    for (int i = int'(KEY_CNT) - 1; i >= 0; i--) begin
      if (vec[i]) lowestSet = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
module evt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdNext;
  logic [CW-1:0]    count;
  logic [CW-1:0]    countNext;
  logic [CW-1:0]    remainOld;
  logic             doPush;
  logic             doPop;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    doPop     = pop && (count != '0);
    doPush    = push && ((count != CW'(DEPTH)) || doPop);
    remainOld = count - CW'(doPop);
    countNext = remainOld + CW'(doPush);
    rdNext    = rdPtr + AW'(doPop);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      head  <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + AW'(1);
      end
      rdPtr <= rdNext;
      count <= countNext;
      empty <= (countNext == '0);
      full  <= (countNext == CW'(DEPTH));
      // Head holds its last value once drained.
      if (countNext != '0) begin
        head <= (remainOld == '0) ? pushData : mem[rdNext];
      end
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column sequencing, frame debounce, press/release event FIFO.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [ROW_CNT-1:0] iROW,
  output logic [3:0]         oCOL,
  input  logic               iIRQ_EN,
  output logic               oIRQ,
  output logic               oEVT_VALID,
  output logic [EVT_W-1:0]   oEVT_DATA,
  input  logic               iEVT_POP,
  output logic [KEY_CNT-1:0] oKEYST,
  output logic               oOVF,
  input  logic               iCLR_OVF
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned STB_W = 4;

  COL_STATE           state;
  COL_STATE           stateNext;
  logic [3:0]         colDriveNext;
  logic [DIV_W-1:0]   divCnt;
  logic               divLast;
  logic               frameEnd;
  logic               frameDone;
  logic [KEY_CNT-1:0] raw;
  logic [KEY_CNT-1:0] prevRaw;
  logic [KEY_CNT-1:0] rawKey;
  logic [STB_W-1:0]   stableCnt;
  logic [STB_W-1:0]   stableNext;
  logic               commit;
  logic [KEY_CNT-1:0] diff;
  logic [CODE_W-1:0]  evtIdx;
  logic               evtPush;
  logic [EVT_W-1:0]   evtData;
  logic               fifoFull;
  logic               fifoEmpty;

  always_comb divLast = (divCnt == DIV_W'(SCAN_DIV - 1));

  // Scan FSM state register; column drive follows the state.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= COL0;
      oCOL  <= 4'b1111;
    end else begin
      state <= stateNext;
      oCOL  <= colDriveNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (divLast) begin
      case (state)
        COL0:    stateNext = COL1;
        COL1:    stateNext = COL2;
        COL2:    stateNext = COL3;
        COL3:    stateNext = COL0;
        default: stateNext = COL0;
      endcase
    end
  end

  always_comb begin
    colDriveNext = COL_DRIVE[stateNext];
    frameEnd     = divLast && (state == COL3);
  end

  // Column dwell counter and row capture into the raw matrix frame.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      divCnt    <= '0;
      raw       <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= frameEnd;
      if (divLast) begin
        divCnt                       <= '0;
        raw[{state, 2'b00} +: ROW_CNT] <= ~iROW;
      end else begin
        divCnt <= divCnt + DIV_W'(1);
      end
    end
  end

  // Remap the matrix frame to key-code order and evaluate the debounce.
  always_comb begin
    rawKey = '0;
    for (int i = 0; i < int'(KEY_CNT); i++) begin
      rawKey[KEYMAP[i]] = raw[i];
    end
    if (raw != prevRaw) begin
      stableNext = '0;
    end else if (stableCnt >= STB_W'(DEBOUNCE_CNT)) begin
      stableNext = STB_W'(DEBOUNCE_CNT);
    end else begin
      stableNext = stableCnt + STB_W'(1);
    end
    commit = frameDone && (stableNext == STB_W'(DEBOUNCE_CNT)) && (rawKey != oKEYST);
  end

  // Serializer emits the lowest pending change each cycle.
  always_comb begin
    evtIdx                 = lowestSet(diff);
    evtPush                = |diff;
    evtData                = '0;
    evtData[EVT_PRESS_BIT] = oKEYST[evtIdx];
    evtData[CODE_W-1:0]    = evtIdx;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      prevRaw   <= '0;
      stableCnt <= '0;
      oKEYST    <= '0;
      diff      <= '0;
    end else if (frameDone) begin
      prevRaw   <= raw;
      stableCnt <= stableNext;
      if (commit) begin
        oKEYST <= rawKey;
        diff   <= rawKey ^ oKEYST;
      end
    end else if (evtPush) begin
      diff[evtIdx] <= 1'b0;
    end
  end

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .push     (evtPush),
    .pushData (evtData),
    .pop      (iEVT_POP),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (oEVT_DATA)
  );

  always_comb oEVT_VALID = ~fifoEmpty;

  // Overflow set wins over clear; IRQ lags FIFO occupancy by one cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oOVF <= 1'b0;
      oIRQ <= 1'b0;
    end else begin
      oIRQ <= ~fifoEmpty & iIRQ_EN;
      if (evtPush && fifoFull && !iEVT_POP) begin
        oOVF <= 1'b1;
      end else if (iCLR_OVF) begin
        oOVF <= 1'b0;
      end
    end
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Autonomous 4x4 keypad scan controller for the PS-attached keypad IP. It sequences the column drive, samples the active-low rows and debounces the whole 16-key matrix frame. It converts debounced changes into press/release events in a small FIFO, which software drains through a valid/pop handshake; a level IRQ is asserted while events are pending.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled; must be >= 8.
DEBOUNCE_CNT, 4, number of additional identical consecutive frames required before a change commits; range 1..15.
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..16.

Ports:
iCLK  in  1  system clock
iRST  in  1  synchronous reset, active-high
iROW  in  4  keypad rows, active-low (0 = key closed on driven column)
oCOL  out  4  column drive, one-cold, active-low
iIRQ_EN  in  1  enable for oIRQ
oIRQ  out  1  level interrupt: FIFO non-empty AND iIRQ_EN
oEVT_VALID  out  1  FIFO non-empty
oEVT_DATA  out  8  FIFO head: [7] 1 = press / 0 = release; [6:4] = 0; [3:0] = key code
iEVT_POP  in  1  consume head; ignored when oEVT_VALID = 0
oKEYST  out  16  debounced key state; bit n = key code n held
oOVF  out  1  sticky: an event was dropped on a full FIFO
iCLR_OVF  in  1  clears oOVF

Behaviour:
- Reset (iRST sampled high): oCOL = 4'b1111; oKEYST = 0; FIFO empty; oEVT_VALID = 0; oEVT_DATA = 0; oIRQ = 0; oOVF = 0; all counters and frames = 0.
- Scan FSM states: COL0, COL1, COL2, COL3. COLk drives oCOL with bit k low. After reset release, the FSM enters COL0.
- In each state, a divider counts 0..SCAN_DIV-1. On count SCAN_DIV-1, ~iROW is latched into raw[k*4 + r] and the FSM advances; COL3 wraps to COL0.
- Sampling COL3 completes the frame and raises frame_done for 1 cycle.
- Debounce, evaluated on frame_done:
  - If raw != prev_raw, stable_cnt = 0.
  - Otherwise, stable_cnt increments, saturating at DEBOUNCE_CNT.
  - prev_raw <= raw.
  - Commit happens when stable_cnt reaches DEBOUNCE_CNT (including staying saturated) and raw != oKEYST. On commit, oKEYST <= raw and diff <= raw ^ oKEYST. A commit therefore needs DEBOUNCE_CNT+1 identical consecutive frames.
- Matrix to key-code map (index c*4 + r; package constant):
  - col0 rows 0..3 = 1, 4, 7, 0
  - col1 rows 0..3 = 2, 5, 8, F
  - col2 rows 0..3 = 3, 6, 9, E
  - col3 rows 0..3 = A, B, C, D
  - oKEYST and diff are indexed by key code, not matrix index.
- Event serializer:
  - Starting the cycle after a commit, each cycle it selects the lowest set diff bit n, pushes {oKEYST[n], 3'b0, n[3:0]}, and clears that bit of diff.
  - It emits one event per cycle, so at most 16 cycles. SCAN_DIV >= 8 guarantees it is idle before the next frame_done.
- FIFO: first-word-fall-through. oEVT_DATA shows the head whenever oEVT_VALID = 1 and holds its last value when empty.
  - Push when full: the event is dropped and oOVF is set.
  - Push and pop in the same cycle when full: both happen and nothing is dropped.
  - Push and pop in the same cycle when empty: not possible (pop is ignored when empty).
- oOVF: set has priority over iCLR_OVF in the same cycle.
- oIRQ is registered: it asserts the cycle after the FIFO becomes non-empty (when iIRQ_EN = 1) and deasserts the cycle after it drains.
- Reset mid-scan or mid-serialization: all state returns to reset values next cycle and pending events are discarded.

Decomposition:
- Package keypad_pkg: COL_STATE enum (COL0..COL3), event bit positions (EVT_PRESS_BIT = 7), 16-entry KEYMAP constant (matrix index to key code), one-cold column drive constant table.
- Sub-module evt_fifo: parameterized sync FWFT FIFO (width 8, FIFO_DEPTH), with push/pop/full/empty ports. The scan FSM, debounce and serializer stay in the top module.

Test Plan (SCAN_DIV=8, DEBOUNCE_CNT=2, FIFO_DEPTH=4):
1. Reset, no keys -> oCOL cycles 1110, 1101, 1011, 0111 every 8 cycles; oKEYST = 0; oEVT_VALID = 0; oIRQ = 0.
2. Hold row 1 low during col2 (key 6) for 4 frames, iIRQ_EN = 1 -> after the 3rd identical frame, oKEYST = 16'h0040 and oEVT_DATA = 8'h86. oIRQ rises 1 cycle after oEVT_VALID. Pop -> empty; oIRQ drops next cycle.
3. Release key 6 for 3 frames -> oEVT_DATA = 8'h06; oKEYST = 0.
4. 2-frame glitch on key 5 followed by release -> no event; oKEYST unchanged.
5. Keys 1, 4, 7, 0 and F pressed together, stable, no pops -> events 80, 81, 84, 87 pushed on consecutive cycles; 8F is dropped; oOVF = 1. iCLR_OVF -> oOVF = 0.
6. Assert iRST during serialization of case 5 -> next cycle FIFO empty, oKEYST = 0, oCOL = 1111; scan restarts at COL0.
